// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 encoder types, opcodes and field limits
package legv8_pkg;

    localparam int INSTR_LEN = 32;
    localparam int WORD      = 64;

    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_D  = 2'd1,
        FMT_CB = 2'd2,
        FMT_B  = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_WRITE,
        ST_HALT
    } state_e;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // Signed immediate field widths; D-format range -256..255 is a 9-bit signed field
    localparam int D_IMM_BITS  = 9;
    localparam int CB_IMM_BITS = 19;
    localparam int B_IMM_BITS  = 26;

    // True when v survives truncation to a bits-wide two's-complement field
    function automatic logic fits_signed(input logic [WORD-1:0] v, input int bits);
        logic [WORD-1:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/legv8_field_pack.sv
// rtl/legv8_field_pack.sv - combinational R/D/CB/B instruction word packer
module legv8_field_pack
    import legv8_pkg::*;
(
    input  logic [1:0]           fmt,
    input  logic [10:0]          opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rn,
    input  logic [4:0]           rm,
    input  logic [5:0]           shamt,
    input  logic [WORD-1:0]      imm,
    output logic [INSTR_LEN-1:0] word,
    output logic                 range_ok
);

    // Pack fields per format and check the immediate fits its field
    always_comb begin
        word     = '0;
        range_ok = 1'b1;
        case (fmt_e'(fmt))
            FMT_R: begin
                word = {opcode, rm, shamt, rn, rd};
            end
            FMT_D: begin
                word     = {opcode, imm[8:0], 2'b00, rn, rd};
                range_ok = fits_signed(imm, D_IMM_BITS);
            end
            FMT_CB: begin
                word     = {opcode[10:3], imm[18:0], rd};
                range_ok = fits_signed(imm, CB_IMM_BITS);
            end
            default: begin
                word     = {opcode[10:5], imm[25:0]};
                range_ok = fits_signed(imm, B_IMM_BITS);
            end
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// rtl/legv8_instr_encoder.sv - instruction encoder and sequential imem program loader
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter logic [WORD-1:0] BASE_ADDR = '0,
    parameter int              DEPTH     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_fmt,
    input  logic [10:0]            in_opcode,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rn,
    input  logic [4:0]             in_rm,
    input  logic [5:0]             in_shamt,
    input  logic [WORD-1:0]        in_imm,
    input  logic                   in_last,
    output logic                   imem_we,
    output logic [WORD-1:0]        imem_addr,
    output logic [INSTR_LEN-1:0]   imem_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    output logic                   err_sticky,
    output logic                   full,
    output logic                   done
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e                state, nxt;
    logic [1:0]            fmt_q;
    logic [10:0]           opcode_q;
    logic [4:0]            rd_q, rn_q, rm_q;
    logic [5:0]            shamt_q;
    logic [WORD-1:0]       imm_q;
    logic                  last_q;
    logic [INSTR_LEN-1:0]  word_q;
    logic [WORD-1:0]       addr_q;
    logic [CW-1:0]         count_q;
    logic                  sticky_q;
    logic                  done_q;
    logic [INSTR_LEN-1:0]  packed_word;
    logic                  range_ok;

    legv8_field_pack u_pack (
        .fmt      (fmt_q),
        .opcode   (opcode_q),
        .rd       (rd_q),
        .rn       (rn_q),
        .rm       (rm_q),
        .shamt    (shamt_q),
        .imm      (imm_q),
        .word     (packed_word),
        .range_ok (range_ok)
    );

    assign full       = (count_q == CW'(DEPTH));
    assign count      = count_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign err_sticky = sticky_q;
    assign done       = done_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= nxt;
    end

    // Next-state and handshake/strobe decode
    always_comb begin
        nxt      = state;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        err      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !full;
                if (in_valid && !full) nxt = ST_ENC;
            end
            ST_ENC: begin
                if (range_ok) begin
                    nxt = ST_WRITE;
                end else begin
                    err = 1'b1;
                    nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                imem_we = 1'b1;
                nxt     = last_q ? ST_HALT : ST_IDLE;
            end
            default: nxt = ST_HALT;
        endcase
    end

    // Input capture, write-port registers, word counter and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            fmt_q    <= '0;
            opcode_q <= '0;
            rd_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            shamt_q  <= '0;
            imm_q    <= '0;
            last_q   <= 1'b0;
            word_q   <= '0;
            addr_q   <= BASE_ADDR;
            count_q  <= '0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                fmt_q    <= in_fmt;
                opcode_q <= in_opcode;
                rd_q     <= in_rd;
                rn_q     <= in_rn;
                rm_q     <= in_rm;
                shamt_q  <= in_shamt;
                imm_q    <= in_imm;
                last_q   <= in_last;
            end
            // Address and data are loaded only for a word that will be written,
            // so both hold their last written values at all other times.
            if (state == ST_ENC && range_ok) begin
                word_q <= packed_word;
                addr_q <= BASE_ADDR + (WORD'(count_q) << 2);
            end
            if (err) sticky_q <= 1'b1;
            if (state == ST_WRITE) begin
                count_q <= count_q + CW'(1);
                if (last_q) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb/tb_legv8_instr_encoder.sv - table-driven scoreboard bench for legv8_instr_encoder
module tb_legv8_instr_encoder;
    import legv8_pkg::*;

    localparam logic [63:0] BASE  = 64'h400;
    localparam int          DEPTH = 4;

    typedef struct {
        logic [1:0]  fmt;
        logic [10:0] op;
        logic [4:0]  rd, rn, rm;
        logic [5:0]  shamt;
        logic [63:0] imm;
        bit          last;
        bit          exp_err;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 0, reset = 1, in_valid = 0, in_last = 0;
    logic        in_ready, imem_we, err, err_sticky, full, done;
    logic [1:0]  in_fmt = 0;
    logic [10:0] in_opcode = 0;
    logic [4:0]  in_rd = 0, in_rn = 0, in_rm = 0;
    logic [5:0]  in_shamt = 0;
    logic [63:0] in_imm = 0, imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;

    vec_t vecs[$];
    wr_t  sb[$];
    int   n_pass = 0, n_total = 0, model_count = 0;

    legv8_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rn(in_rn),
        .in_rm(in_rm), .in_shamt(in_shamt), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .err(err), .err_sticky(err_sticky), .full(full), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void add(input logic [1:0] f, input logic [10:0] op, input int rd, input int rn,
                                input int rm, input int sh, input longint imm, input bit e,
                                input logic [31:0] w);
        vec_t v;
        v.fmt = f; v.op = op; v.rd = 5'(rd); v.rn = 5'(rn); v.rm = 5'(rm); v.shamt = 6'(sh);
        v.imm = 64'(imm); v.last = 0; v.exp_err = e; v.exp_word = w;
        vecs.push_back(v);
    endfunction

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(imem_we), 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", imem_addr, e.addr);
                chk("wr_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    task automatic drive(input vec_t v);
        in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rn = v.rn; in_rm = v.rm;
        in_shamt = v.shamt; in_imm = v.imm; in_last = v.last;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1; in_valid = 0;
        @(negedge clk);
        @(negedge clk); reset = 0;
        sb.delete();
        model_count = 0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        chk("rst_imem_addr", imem_addr, BASE);
        chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_flags", {err, err_sticky, full, done}, 64'd0);
    endtask

    // One handshake with cycle-exact checks of the ENC and WRITE slots
    task automatic send(input vec_t v);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        drive(v);
        in_valid = 1;
        if (!v.exp_err) sb.push_back('{BASE + 64'(4 * model_count), v.exp_word});
        @(negedge clk); in_valid = 0;
        chk("enc_err", 64'(err), 64'(v.exp_err));
        chk("enc_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("write_slot_we", 64'(imem_we), 64'(!v.exp_err));
        if (!v.exp_err) model_count++;
        @(negedge clk);
        chk("count", 64'(count), 64'(model_count));
        chk("sb_drained", 64'(sb.size()), 64'd0);
        if (v.exp_err) chk("err_sticky", 64'(err_sticky), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        add(FMT_R,  OP_ADD,              10, 19, 9,  0,  0,         0, 32'h8B09026A);
        add(FMT_D,  OP_LDUR,             9,  22, 0,  0,  64,        0, 32'hF84402C9);
        add(FMT_D,  OP_STUR,             11, 22, 0,  0,  96,        0, 32'hF80602CB);
        add(FMT_CB, {OP_CBNZ, 3'b000},   11, 0,  0,  0,  -5,        0, 32'hB5FFFF6B);
        add(FMT_B,  {OP_B, 5'b00000},    0,  0,  0,  0,  -55,       0, 32'h17FFFFC9);
        add(FMT_D,  OP_LDUR,             9,  22, 0,  0,  256,       1, 32'h0);
        add(FMT_B,  {OP_B, 5'b00000},    0,  0,  0,  0,  64,        0, 32'h14000040);
        add(FMT_CB, {OP_CBZ, 3'b000},    9,  0,  0,  0,  8,         0, 32'hB4000109);
        add(FMT_D,  OP_LDUR,             1,  2,  0,  0,  -257,      1, 32'h0);
        add(FMT_D,  OP_LDUR,             1,  2,  0,  0,  -256,      0, 32'hF8500041);
        add(FMT_D,  OP_STUR,             0,  0,  0,  0,  255,       0, 32'hF80FF000);
        add(FMT_B,  {OP_B, 5'b00000},    0,  0,  0,  0,  33554431,  0, 32'h15FFFFFF);
        add(FMT_B,  {OP_B, 5'b00000},    0,  0,  0,  0,  33554432,  1, 32'h0);
        add(FMT_CB, {OP_CBZ, 3'b000},    0,  0,  0,  0,  -262144,   0, 32'hB4800000);
        add(FMT_CB, {OP_CBZ, 3'b000},    0,  0,  0,  0,  262144,    1, 32'h0);
        add(FMT_R,  OP_AND,              31, 0,  31, 63, -64'sd1 <<< 63, 0, 32'h8A1FFC1F);
        add(FMT_R,  OP_SUB,              1,  2,  3,  0,  0,         0, 32'hCB030041);

        do_reset();
        foreach (vecs[i]) begin
            if (model_count == DEPTH) do_reset();
            send(vecs[i]);
        end

        // Fill to DEPTH, then a further request must be ignored
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(vecs[i < 5 ? i : 6]);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(vecs[0]); in_valid = 1;
        repeat (4) @(negedge clk);
        in_valid = 0;
        chk("full_count_held", 64'(count), 64'(DEPTH));
        chk("full_not_done", 64'(done), 64'd0);

        // in_last on the second word halts the loader
        do_reset();
        send(vecs[0]);
        v = vecs[1]; v.last = 1;
        send(v);
        chk("done_flag", 64'(done), 64'd1);
        chk("done_in_ready", 64'(in_ready), 64'd0);
        chk("done_not_full", 64'(full), 64'd0);
        drive(vecs[2]); in_valid = 1;
        repeat (4) @(negedge clk);
        in_valid = 0;
        chk("done_count_held", 64'(count), 64'd2);

        // in_last on a dropped word is ignored
        do_reset();
        v = vecs[5]; v.last = 1;
        send(v);
        chk("dropped_last_done", 64'(done), 64'd0);
        chk("dropped_last_ready", 64'(in_ready), 64'd1);

        // Reset while a valid word sits in ENC: no write, everything back to reset values
        do_reset();
        send(vecs[5]);
        @(negedge clk);
        drive(vecs[0]); in_valid = 1;
        @(negedge clk); in_valid = 0;
        reset = 1;
        @(negedge clk);
        chk("rst_enc_we", 64'(imem_we), 64'd0);
        chk("rst_enc_count", 64'(count), 64'd0);
        chk("rst_enc_addr", imem_addr, BASE);
        chk("rst_enc_sticky", 64'(err_sticky), 64'd0);
        reset = 0;
        @(negedge clk);
        chk("rst_enc_we_after", 64'(imem_we), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
